// File: rtl/csel_pkg.sv
// csel_pkg: shared defaults and helpers for the pipelined carry-select adder.
//   CSEL_WIDTH      - default operand/sum width
//   CSEL_BLK        - default bits per carry-select block
//   CSEL_PIPE_EVERY - default carry-select blocks per pipeline stage
//   csel_lat()      - pipeline latency in cycles for a given configuration
package csel_pkg;

  localparam int CSEL_WIDTH      = 32;
  localparam int CSEL_BLK        = 4;
  localparam int CSEL_PIPE_EVERY = 2;

  // One register stage per group of PIPE_EVERY blocks; the last stage's
  // registers are the outputs, so latency equals the stage count.
  function automatic int csel_lat(input int width, input int blk, input int pipe_every);
    return width / (blk * pipe_every);
  endfunction

endpackage

// File: rtl/csel_adder_pipe_if.sv
// csel_adder_pipe_if: operand/result handshake bundle for csel_adder_pipe.
//   in_valid/in_ready   - operand handshake (A, B, cin, sub)
//   out_valid/out_ready - result handshake (sum, cout, ovf)
//   master - producer/consumer side (drives operands, takes results)
//   slave  - adder side
interface csel_adder_pipe_if
  import csel_pkg::*;
#(
  parameter int WIDTH = CSEL_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, A, B, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, A, B, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/csel_block.sv
// csel_block: one combinational carry-select block.
//   a, b - BLK-bit operand slices (b already inverted for subtraction)
//   ci   - carry into the block, used only as the select
//   s    - BLK-bit block sum
//   co   - carry out of the block
module csel_block #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           ci,
  output logic [BLK-1:0] s,
  output logic           co
);

  logic [BLK:0] sum0;
  logic [BLK:0] sum1;

  // Both candidate sums are ready before the incoming carry settles.
  assign sum0 = {1'b0, a} + {1'b0, b};
  assign sum1 = {1'b0, a} + {1'b0, b} + (BLK+1)'(1);

  assign {co, s} = ci ? sum1 : sum0;

endmodule

// File: rtl/csel_adder_pipe.sv
// csel_adder_pipe: pipelined carry-select adder/subtractor.
//   clk - clock, rising edge
//   rst - synchronous active-high reset
//   bus - csel_adder_pipe_if.slave:
//           in_valid/in_ready, A, B, cin, sub   operand side
//           out_valid/out_ready, sum, cout, ovf result side
// Block 0 ripples; blocks 1..NBLK-1 are csel_block instances. Every
// PIPE_EVERY blocks form a stage whose carry, finished low sum bits and
// remaining operand bits are registered. A single enable stalls the whole
// pipe while a result waits at the output.
module csel_adder_pipe
  import csel_pkg::*;
#(
  parameter int WIDTH      = CSEL_WIDTH,
  parameter int BLK        = CSEL_BLK,
  parameter int PIPE_EVERY = CSEL_PIPE_EVERY
) (
  input  logic               clk,
  input  logic               rst,
  csel_adder_pipe_if.slave   bus
);

  localparam int NBLK = WIDTH / BLK;
  localparam int NSTG = NBLK / PIPE_EVERY;
  localparam int LAT  = csel_lat(WIDTH, BLK, PIPE_EVERY);

  localparam bit BAD_CFG = (BLK < 1) || (PIPE_EVERY < 1) ? 1'b1
                         : ((WIDTH % (BLK * PIPE_EVERY)) != 0);

  if (BAD_CFG) begin : g_bad_cfg
    $error("csel_adder_pipe: WIDTH must be a multiple of BLK*PIPE_EVERY and BLK >= 1");
  end

  if (LAT != NSTG) begin : g_bad_lat
    $error("csel_adder_pipe: latency helper disagrees with stage count");
  end

  // Pipeline state, one entry per stage
  logic             vld_q [NSTG];
  logic [WIDTH-1:0] a_q   [NSTG];
  logic [WIDTH-1:0] b_q   [NSTG];
  logic [WIDTH-1:0] s_q   [NSTG];
  logic             c_q   [NSTG];

  // Per-stage sources (stage 0 from the bus, stage k from stage k-1)
  logic             src_v [NSTG];
  logic [WIDTH-1:0] src_a [NSTG];
  logic [WIDTH-1:0] src_b [NSTG];
  logic [WIDTH-1:0] src_s [NSTG];
  logic             src_c [NSTG];

  // Next-state values
  logic [WIDTH-1:0] s_d [NSTG];
  logic             c_d [NSTG];

  // Block results
  logic [BLK-1:0]   blk_s [NBLK];
  logic             blk_co [NBLK];

  logic             en;

  // Holding the output also holds every stage behind it.
  assign en = !(vld_q[NSTG-1] && !bus.out_ready);

  // ---- stage sources ----
  for (genvar k = 0; k < NSTG; k++) begin : g_src
    if (k == 0) begin : g_in
      // Subtraction is A + ~B + 1; cin is ignored then.
      assign src_v[k] = bus.in_valid;
      assign src_a[k] = bus.A;
      assign src_b[k] = bus.B ^ {WIDTH{bus.sub}};
      assign src_s[k] = '0;
      assign src_c[k] = bus.sub | bus.cin;
    end else begin : g_reg
      assign src_v[k] = vld_q[k-1];
      assign src_a[k] = a_q[k-1];
      assign src_b[k] = b_q[k-1];
      assign src_s[k] = s_q[k-1];
      assign src_c[k] = c_q[k-1];
    end
  end

  // ---- blocks ----
  for (genvar j = 0; j < NBLK; j++) begin : g_blk
    localparam int STG = j / PIPE_EVERY;
    logic ci;

    // The first block of a stage takes the registered stage carry.
    if ((j % PIPE_EVERY) == 0) begin : g_first
      assign ci = src_c[STG];
    end else begin : g_chain
      assign ci = blk_co[j-1];
    end

    if (j == 0) begin : g_ripple
      logic [BLK-1:0] rs;
      logic [BLK:0]   rc;

      always_comb begin
        rs    = '0;
        rc    = '0;
        rc[0] = ci;
        for (int i = 0; i < BLK; i++) begin
          rs[i]   = src_a[STG][i] ^ src_b[STG][i] ^ rc[i];
          rc[i+1] = (src_a[STG][i] & src_b[STG][i]) |
                    (rc[i] & (src_a[STG][i] ^ src_b[STG][i]));
        end
      end

      assign blk_s[j]  = rs;
      assign blk_co[j] = rc[BLK];
    end else begin : g_sel
      csel_block #(
        .BLK (BLK)
      ) u_blk (
        .a  (src_a[STG][j*BLK +: BLK]),
        .b  (src_b[STG][j*BLK +: BLK]),
        .ci (ci),
        .s  (blk_s[j]),
        .co (blk_co[j])
      );
    end
  end

  // ---- stage next state ----
  always_comb begin
    for (int k = 0; k < NSTG; k++) begin
      s_d[k] = src_s[k];
      for (int p = 0; p < PIPE_EVERY; p++) begin
        s_d[k][(k*PIPE_EVERY + p)*BLK +: BLK] = blk_s[k*PIPE_EVERY + p];
      end
      c_d[k] = blk_co[(k+1)*PIPE_EVERY - 1];
    end
  end

  // ---- stage registers: valid bits ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NSTG; k++) begin
        vld_q[k] <= 1'b0;
      end
    end else if (en) begin
      for (int k = 0; k < NSTG; k++) begin
        vld_q[k] <= src_v[k];
      end
    end
  end

  // ---- stage registers: data (only the output stage is cleared) ----
  always_ff @(posedge clk) begin
    for (int k = 0; k < NSTG; k++) begin
      if (rst && (k == NSTG-1)) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end else if (en) begin
        a_q[k] <= src_a[k];
        b_q[k] <= src_b[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
      end
    end
  end

  // ---- outputs ----
  // Carry into the MSB is recovered as a^b^s at the MSB.
  assign bus.in_ready  = en;
  assign bus.out_valid = vld_q[NSTG-1];
  assign bus.sum       = s_q[NSTG-1];
  assign bus.cout      = c_q[NSTG-1];
  assign bus.ovf       = c_q[NSTG-1] ^
                         (a_q[NSTG-1][WIDTH-1] ^ b_q[NSTG-1][WIDTH-1] ^ s_q[NSTG-1][WIDTH-1]);

endmodule
